pixel_writer: RTL
=================

Name: pixel_writer

Overview:
- Downstream stage of the circle-drawing state machine: consumes its plot/x/y/colour pixel stream and writes it into the 160x120, 3-bit-colour framebuffer RAM port.
- Clips off-screen coordinates, which occur because centre±offset wraps in 8/7-bit arithmetic.
- Converts (x,y) to a linear address and buffers pixels in a small FIFO to absorb memory backpressure.
- Provides a full-screen clear-to-background mode.

Parameters:
- SCREEN_W, 160, visible width; x valid when x < SCREEN_W.
- SCREEN_H, 120, visible height; y valid when y < SCREEN_H.
- DEPTH, 8, FIFO entries (power of two, >= 2).
- BG_COLOUR, 3'b000, colour written by a clear.

Ports:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- plot  in  1  pixel valid, one pixel per cycle when high.
- x  in  8  pixel column.
- y  in  7  pixel row.
- colour  in  3  pixel colour.
- clear_req  in  1  single-cycle pulse: clear the screen to BG_COLOUR.
- mem_ready  in  1  RAM accepts the write this cycle.
- mem_we  out  1  write request.
- mem_addr  out  15  linear address y*160+x.
- mem_data  out  3  write colour.
- busy  out  1  high in CLEAR or while the FIFO is non-empty.
- clipped  out  1  one-cycle pulse, cycle after an off-screen plot.
- overflow  out  1  sticky; pixel dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, resetn=0):
  - FIFO empty, state IDLE, clear counter 0.
  - mem_we=0, mem_addr=0, mem_data=0, busy=0, clipped=0, overflow=0.
  - Takes effect mid-operation too; an in-progress clear or drain is abandoned with no further writes.
- Address: addr = (y<<7)+(y<<5)+x, computed at 15 bits with no truncation; maximum 19199.
- Accept rule, on plot=1:
  - x>=SCREEN_W or y>=SCREEN_H: pixel discarded, clipped=1 next cycle.
  - Otherwise {addr,colour} is pushed.
- Full FIFO:
  - Push accepted if a pop happens in the same cycle; count unchanged.
  - Otherwise pixel dropped and overflow set. overflow clears only on reset.
- Latency: a pixel pushed at edge N appears on mem_we/mem_addr/mem_data in the cycle after edge N; no same-cycle bypass.
- Handshake:
  - mem_we, mem_addr and mem_data are driven from the FIFO head (DRAIN) or the clear counter (CLEAR).
  - A transfer completes on an edge where mem_we && mem_ready.
  - While mem_we=1 and mem_ready=0, mem_addr and mem_data hold stable.
  - mem_we never deasserts without a completed transfer, except on reset or on IDLE/DRAIN->CLEAR.
- Ordering: FIFO pixels are written strictly in acceptance order.
- States:
  - IDLE: FIFO empty, mem_we=0. Non-empty FIFO -> DRAIN. clear_req -> CLEAR.
  - DRAIN: mem_we=1 with the head entry; pop on transfer. Goes to IDLE when the last entry pops and no push occurs that cycle. clear_req -> CLEAR.
  - CLEAR:
    - mem_we=1, mem_addr=counter, mem_data=BG_COLOUR.
    - Counter increments on each transfer.
    - On the transfer at 19199, counter resets to 0; then -> DRAIN if the FIFO is non-empty, else IDLE.
- clear_req handling:
  - On entry to CLEAR, all FIFO entries present before that edge are discarded; the clear overwrites them.
  - A plot in the same cycle as clear_req is pushed and kept.
  - Plots during CLEAR are accepted into the FIFO, and written after the clear.
  - clear_req while in CLEAR is ignored; the counter is not restarted.
- busy = (state==CLEAR) || FIFO non-empty; combinational from registered state.
- Pointers: wrap modulo DEPTH; full/empty distinguished by an extra pointer bit or count register.

Test Plan:
- Reset, mem_ready=1, plot x=10 y=5 colour=3 for one cycle -> next cycle mem_we=1, mem_addr=810, mem_data=3, for exactly one cycle; then busy=0.
- plot (160,0), then (5,120), then (159,119) colour=7 -> clipped pulses twice; exactly one write, addr=19199 data=7.
- mem_ready=0, DEPTH=8, 9 plots of (i,0) colour=i%8, i=0..8 -> overflow=1 after the 9th; mem_addr stays 0; release ready -> 8 writes, addr 0..7, in order.
- mem_ready pattern 1,0,0,1,0,1 during 3 queued pixels -> addr/data constant across low-ready cycles; each pixel written exactly once.
- Queue 2 pixels with mem_ready=0, pulse clear_req, plot (3,2) colour=5 during the clear, then mem_ready=1 -> 19200 writes addr 0..19199 data 0, then one write addr 323 data 5; the 2 queued pixels are never written.
- resetn low at clear count 500 -> mem_we=0, busy=0, all outputs 0 immediately (asynchronous, before the next edge); after release, the state is IDLE and no writes occur.

Source files
------------

// File: rtl/pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_writer
// Purpose  : Takes the plot/x/y/colour pixel stream from the circle drawer,
//            clips off-screen pixels, converts (x,y) to a linear framebuffer
//            address, buffers pixels in a small FIFO against RAM backpressure
//            and offers a full-screen clear to BG_COLOUR.
// Ports    : clock      - sole clock, rising edge
//            resetn     - asynchronous active-low reset
//            plot       - pixel valid (one pixel per cycle)
//            x, y       - pixel column (8b) / row (7b)
//            colour     - pixel colour (3b)
//            clear_req  - single-cycle pulse, clear the screen
//            mem_ready  - RAM accepts the write this cycle
//            mem_we     - write request
//            mem_addr   - linear address y*160+x (15b)
//            mem_data   - write colour (3b)
//            busy       - clearing, or FIFO non-empty
//            clipped    - one-cycle pulse after an off-screen plot
//            overflow   - sticky, a pixel was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module pixel_writer #(
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter int         DEPTH     = 8,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        clear_req,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        busy,
    output logic        clipped,
    output logic        overflow
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [7:0]  X_LIM     = 8'(SCREEN_W);
    localparam logic [6:0]  Y_LIM     = 7'(SCREEN_H);
    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);
    localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [14:0]   cnt_q, cnt_d;
    logic          clipped_q, clipped_d;
    logic          overflow_q, overflow_d;

    // Each entry holds {address, colour}
    logic [17:0]   fifo_mem [DEPTH];

    logic          w_in_range;
    logic          w_accept;
    logic          w_clear_start;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic [AW:0]   w_count;
    logic [AW:0]   w_count_next;
    logic [14:0]   w_addr;

    // y*160 + x as (y<<7)+(y<<5)+x, all terms zero-extended to 15 bits
    assign w_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};

    assign w_in_range    = (x < X_LIM) && (y < Y_LIM);
    assign w_accept      = plot && w_in_range;
    assign w_clear_start = clear_req && (state_q != S_CLEAR);
    assign w_count       = wr_ptr_q - rd_ptr_q;
    assign w_full        = (w_count == FULL_CNT);
    // DRAIN is only ever occupied with a non-empty FIFO, so no empty check
    assign w_pop         = (state_q == S_DRAIN) && mem_ready;
    // Entering CLEAR flushes the FIFO, so a same-cycle plot always fits
    assign w_push        = w_accept && (w_clear_start || !w_full || w_pop);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, w_push};
        rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, w_pop};
        clipped_d    = plot && !w_in_range;
        overflow_d   = overflow_q | (w_accept && !w_push);

        // Discard everything queued before this edge; the clear covers it
        if (w_clear_start) begin
            rd_ptr_d = wr_ptr_q;
        end

        // Occupancy after this edge decides the next state, so a pixel pushed
        // now is presented on the RAM port in the very next cycle
        w_count_next = wr_ptr_d - rd_ptr_d;

        case (state_q)
            S_IDLE: begin
                if (w_clear_start) begin
                    state_d = S_CLEAR;
                end else if (w_count_next != '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_clear_start) begin
                    state_d = S_CLEAR;
                end else if (w_count_next == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (mem_ready) begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = (w_count_next != '0) ? S_DRAIN : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 15'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            clipped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            clipped_q  <= clipped_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers define which entries are live
    always_ff @(posedge clock) begin
        if (w_push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {w_addr, colour};
        end
    end

    // RAM port decoded from registered state only, so a reset clears it at once
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        case (state_q)
            S_DRAIN: begin
                mem_we                 = 1'b1;
                {mem_addr, mem_data}   = fifo_mem[rd_ptr_q[AW-1:0]];
            end
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                mem_data = BG_COLOUR;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign busy     = (state_q == S_CLEAR) || (w_count != '0);
    assign clipped  = clipped_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire
